// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer.
package pipeline_sequencer_pkg;

  // Sequencer states; the encoding is visible on o_state.
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'b00,
    SEQ_RUN    = 2'b01,
    SEQ_STEP   = 2'b10,
    SEQ_HALTED = 2'b11
  } seq_state_e;

  // MIPS register-file address width and the hard-wired zero register.
  localparam int         REG_W    = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // The pipeline advances only while running freely or taking a single step.
  function automatic logic is_active(input seq_state_e s);
    return (s == SEQ_RUN) || (s == SEQ_STEP);
  endfunction

endpackage : pipeline_sequencer_pkg

// File: rtl/pipeline_sequencer_load_use_detector.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load still in EX. ALU forwarding cannot cover this case,
// so one bubble is needed. Purely combinational so the debug-unit status
// logic can reuse it.
module load_use_detector
  import pipeline_sequencer_pkg::*;
(
  input  logic             i_mem_rd_EX,
  input  logic [REG_W-1:0] i_rt_EX,
  input  logic [REG_W-1:0] i_rs_ID,
  input  logic [REG_W-1:0] i_rt_ID,
  output logic             o_lu
);

  // A load into $zero never creates a dependency.
  always_comb begin
    o_lu = i_mem_rd_EX
         && (i_rt_EX != REG_ZERO)
         && ((i_rt_EX == i_rs_ID) || (i_rt_EX == i_rt_ID));
  end

endmodule : load_use_detector

// File: rtl/pipeline_sequencer.sv
// Global run/step/halt controller for the 5-stage MIPS pipeline.
// Gates the pipeline registers and the PC, inserts the load-use bubble,
// flushes IF/ID on a taken branch and keeps cycle/stall statistics.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int          CYC_W      = 32,
  parameter logic [31:0] MAX_CYCLES = 32'hFFFF_F
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic             i_halt_WB,
  input  logic             i_mem_rd_EX,
  input  logic [REG_W-1:0] i_rt_EX,
  input  logic [REG_W-1:0] i_rs_ID,
  input  logic [REG_W-1:0] i_rt_ID,
  input  logic             i_branch_taken,
  output logic             o_pipe_en,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [1:0]       o_state,
  output logic             o_timeout,
  output logic [CYC_W-1:0] o_cycle_cnt,
  output logic [CYC_W-1:0] o_stall_cnt
);

  // Watchdog fires on the active cycle that would make the count MAX_CYCLES.
  localparam bit               WD_EN    = (MAX_CYCLES != 32'd0);
  localparam logic [CYC_W-1:0] WD_LIMIT = CYC_W'(MAX_CYCLES - 32'd1);
  localparam logic [CYC_W-1:0] CNT_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0] CNT_MAX  = '1;

  seq_state_e       state_q, state_d;
  logic             timeout_q, timeout_d;
  logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CYC_W-1:0] stall_cnt_q, stall_cnt_d;

  logic active;
  logic lu;
  logic wd_hit;

  load_use_detector u_lu (
    .i_mem_rd_EX (i_mem_rd_EX),
    .i_rt_EX     (i_rt_EX),
    .i_rs_ID     (i_rs_ID),
    .i_rt_ID     (i_rt_ID),
    .o_lu        (lu)
  );

  assign active = is_active(state_q);
  assign wd_hit = WD_EN && (cycle_cnt_q == WD_LIMIT);

  // Pipeline gating: zero-latency decode of the registered state and the
  // hazard inputs of the current cycle. Everything is off when not active.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_pipe_en     = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (active) begin
      o_pipe_en     = 1'b1;
      o_pc_en       = ~lu;
      o_if_id_en    = ~lu;
      o_id_ex_flush = lu;
      // A stall holds the branch in ID; it re-resolves next cycle, so the
      // flush is deferred rather than lost.
      o_if_id_flush = i_branch_taken & ~lu;
    end
  end

  // Next-state logic for the debug-controlled run/step/halt FSM.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (i_run) begin
          state_d = SEQ_RUN;
        end else if (i_step) begin
          state_d = SEQ_STEP;
        end
      end
      SEQ_RUN: begin
        if (i_halt_WB || wd_hit) begin
          state_d = SEQ_HALTED;
          if (wd_hit) begin
            timeout_d = 1'b1;
          end
        end else if (!i_run) begin
          state_d = SEQ_IDLE;
        end
      end
      // A step always lasts one cycle; a held i_step must pass through
      // IDLE before it can step again.
      SEQ_STEP: begin
        state_d = i_halt_WB ? SEQ_HALTED : SEQ_IDLE;
      end
      // Only i_clear leaves HALTED; run and step requests are ignored.
      SEQ_HALTED: begin
        if (i_clear) begin
          state_d   = SEQ_IDLE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Saturating cycle and stall counters; cleared when leaving HALTED.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == SEQ_HALTED) && i_clear) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
    end else if (active) begin
      if (cycle_cnt_q != CNT_MAX) begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      end
      if (lu && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  // State and statistics registers; reset discards any step or stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= SEQ_IDLE;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_timeout   = timeout_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule : pipeline_sequencer

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer. Two instances share all inputs:
// dut_a uses the default watchdog limit, dut_b a limit of 8 cycles.
module tb_pipeline_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_run, i_step, i_clear, i_halt_WB;
  logic       i_mem_rd_EX, i_branch_taken;
  logic [4:0] i_rt_EX, i_rs_ID, i_rt_ID;

  logic        a_pipe_en, a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_timeout;
  logic [1:0]  a_state;
  logic [31:0] a_cycle_cnt, a_stall_cnt;
  logic        b_pipe_en, b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_timeout;
  logic [1:0]  b_state;
  logic [31:0] b_cycle_cnt, b_stall_cnt;

  pipeline_sequencer dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
    .i_halt_WB(i_halt_WB), .i_mem_rd_EX(i_mem_rd_EX), .i_rt_EX(i_rt_EX), .i_rs_ID(i_rs_ID),
    .i_rt_ID(i_rt_ID), .i_branch_taken(i_branch_taken),
    .o_pipe_en(a_pipe_en), .o_pc_en(a_pc_en), .o_if_id_en(a_if_id_en),
    .o_if_id_flush(a_if_id_flush), .o_id_ex_flush(a_id_ex_flush), .o_state(a_state),
    .o_timeout(a_timeout), .o_cycle_cnt(a_cycle_cnt), .o_stall_cnt(a_stall_cnt)
  );

  pipeline_sequencer #(.CYC_W(32), .MAX_CYCLES(32'd8)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
    .i_halt_WB(i_halt_WB), .i_mem_rd_EX(i_mem_rd_EX), .i_rt_EX(i_rt_EX), .i_rs_ID(i_rs_ID),
    .i_rt_ID(i_rt_ID), .i_branch_taken(i_branch_taken),
    .o_pipe_en(b_pipe_en), .o_pc_en(b_pc_en), .o_if_id_en(b_if_id_en),
    .o_if_id_flush(b_if_id_flush), .o_id_ex_flush(b_id_ex_flush), .o_state(b_state),
    .o_timeout(b_timeout), .o_cycle_cnt(b_cycle_cnt), .o_stall_cnt(b_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  wire [7:0] a_ctl = {a_state, a_pipe_en, a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_timeout};
  wire [7:0] b_ctl = {b_state, b_pipe_en, b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_timeout};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // States are the o_state codes: 0 idle, 1 run, 2 step, 3 halted.
  int              m_st  [2];
  longint unsigned m_cyc [2];
  longint unsigned m_stl [2];
  bit              m_to  [2];

  function automatic longint unsigned max_of(input int k);
    return (k == 0) ? 64'h000F_FFFF : 64'd8;
  endfunction

  function automatic bit model_lu();
    return i_mem_rd_EX && (i_rt_EX != 5'd0) && ((i_rt_EX == i_rs_ID) || (i_rt_EX == i_rt_ID));
  endfunction

  function automatic logic [7:0] model_ctl(input int k);
    bit act;
    bit lu;
    act = (m_st[k] == 1) || (m_st[k] == 2);
    lu  = model_lu();
    return {2'(m_st[k]), act, act && !lu, act && !lu, act && i_branch_taken && !lu, act && lu, m_to[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cyc[k] = 0; m_stl[k] = 0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit act;
      bit lu;
      bit wd;
      int nxt;
      act = (m_st[k] == 1) || (m_st[k] == 2);
      lu  = model_lu();
      nxt = m_st[k];
      case (m_st[k])
        0: if (i_run) nxt = 1; else if (i_step) nxt = 2;
        1: begin
          wd = (max_of(k) != 0) && (m_cyc[k] == max_of(k) - 1);
          if (i_halt_WB || wd) begin
            nxt = 3;
            if (wd) m_to[k] = 1'b1;
          end else if (!i_run) nxt = 0;
        end
        2: nxt = i_halt_WB ? 3 : 0;
        default: if (i_clear) begin
          nxt = 0; m_cyc[k] = 0; m_stl[k] = 0; m_to[k] = 1'b0;
        end
      endcase
      if (act) begin
        if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
        if (lu && m_stl[k] < 64'hFFFF_FFFF) m_stl[k]++;
      end
      m_st[k] = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s ctl a", tag), a_ctl, model_ctl(0));
    check($sformatf("%s cycles a", tag), a_cycle_cnt, m_cyc[0]);
    check($sformatf("%s stalls a", tag), a_stall_cnt, m_stl[0]);
    check($sformatf("%s ctl b", tag), b_ctl, model_ctl(1));
    check($sformatf("%s cycles b", tag), b_cycle_cnt, m_cyc[1]);
    check($sformatf("%s stalls b", tag), b_stall_cnt, m_stl[1]);
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n) model_step();
    @(negedge i_clk);
  endtask

  task automatic set_in(input logic run, input logic step, input logic clr, input logic halt,
                        input logic mem, input logic [4:0] rte, input logic [4:0] rsi,
                        input logic [4:0] rti, input logic br);
    i_run = run; i_step = step; i_clear = clr; i_halt_WB = halt;
    i_mem_rd_EX = mem; i_rt_EX = rte; i_rs_ID = rsi; i_rt_ID = rti; i_branch_taken = br;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_reset();
    tick();
    i_rst_n = 1'b1;
  endtask

  typedef struct {
    logic       mem_rd;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       br;
    logic [4:0] exp_en;  // {pipe_en, pc_en, if_id_en, if_id_flush, id_ex_flush}
    int         lu;
  } vec_t;

  vec_t tbl [8];
  int   exp_stall;

  initial begin
    tbl[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'b11100, 0};
    tbl[1] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 5'b10001, 1};
    tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 5'b11100, 0};
    tbl[3] = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 5'b10001, 1};
    tbl[4] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 5'b11100, 0};
    tbl[5] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'b11110, 0};
    tbl[6] = '{1'b1, 5'd3,  5'd3,  5'd0,  1'b1, 5'b10001, 1};
    tbl[7] = '{1'b1, 5'd31, 5'd30, 5'd29, 1'b1, 5'b11110, 0};

    i_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    model_reset();
    #1;
    check("reset ctl a", a_ctl, 8'h00);
    check("reset cycles a", a_cycle_cnt, 0);
    check("reset stalls a", a_stall_cnt, 0);
    tick();
    i_rst_n = 1'b1;

    // Continuous run, no hazards: one IDLE cycle, then ten active cycles.
    set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #1 check("run idle first cycle", a_ctl, 8'h00);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("run cycle %0d ctl", i), a_ctl, 8'h78);
      tick();
    end
    check("run cycles", a_cycle_cnt, 10);
    check("run stalls", a_stall_cnt, 0);

    // Hazard table while running.
    exp_stall = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 0, tbl[i].mem_rd, tbl[i].rt_ex, tbl[i].rs_id, tbl[i].rt_id, tbl[i].br);
      #1 check($sformatf("tbl %0d enables", i),
               {a_pipe_en, a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush}, tbl[i].exp_en);
      tick();
      exp_stall += tbl[i].lu;
      check($sformatf("tbl %0d stalls", i), a_stall_cnt, exp_stall);
    end
    check("tbl cycles", a_cycle_cnt, 18);

    // Halt from WB, requests ignored while halted, then clear.
    set_in(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    set_in(1, 1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1);
    #1 check("halted ctl", a_ctl, 8'hC0);
    tick();
    tick();
    check("halted ignores run/step", a_state, 2'b11);
    check("halted keeps cycles", a_cycle_cnt, 19);
    set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #1 check("clear ctl", a_ctl, 8'h00);
    check("clear cycles", a_cycle_cnt, 0);
    check("clear stalls", a_stall_cnt, 0);

    // Single step pulse.
    i_step = 1'b1;
    #1 check("step request idle", a_pipe_en, 1'b0);
    tick();
    i_step = 1'b0;
    #1 check("step cycle ctl", a_ctl, 8'hB8);
    tick();
    check("step back to idle", a_state, 2'b00);
    check("step cycles", a_cycle_cnt, 1);
    // Held step alternates STEP / IDLE.
    i_step = 1'b1;
    tick(); check("held step 1", a_state, 2'b10);
    tick(); check("held step 2", a_state, 2'b00);
    tick(); check("held step 3", a_state, 2'b10);
    i_step = 1'b0;
    tick(); check("held step cycles", a_cycle_cnt, 3);
    // Run wins over step; dropping run pauses to IDLE.
    i_run = 1'b1; i_step = 1'b1;
    tick(); check("run beats step", a_state, 2'b01);
    i_run = 1'b0; i_step = 1'b0;
    tick(); check("run pause", a_state, 2'b00);
    // Step that retires HALT.
    i_step = 1'b1;
    tick();
    i_step = 1'b0; i_halt_WB = 1'b1;
    tick(); check("step into halt", a_state, 2'b11);
    i_halt_WB = 1'b0;

    // Watchdog on dut_b: halts after exactly 8 active cycles.
    do_reset();
    i_run = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("wd 7 cycles still run", b_state, 2'b01);
    tick();
    check("wd halted", b_state, 2'b11);
    check("wd timeout", b_timeout, 1'b1);
    check("wd cycles", b_cycle_cnt, 8);
    check("no wd on default", {a_state, a_timeout}, 3'b010);
    tick(); tick();
    check("wd cycles frozen", b_cycle_cnt, 8);
    // Asynchronous reset mid-run clears outputs at once.
    i_branch_taken = 1'b1;
    #1 check("pre-reset flush", a_if_id_flush, 1'b1);
    i_rst_n = 1'b0;
    model_reset();
    #1 check("async reset ctl a", a_ctl, 8'h00);
    check("async reset cycles a", a_cycle_cnt, 0);
    check("async reset ctl b", b_ctl, 8'h00);
    tick();
    i_rst_n = 1'b1;
    i_branch_taken = 1'b0;
    // Watchdog and HALT in the same cycle: timeout is still flagged.
    tick();
    for (int i = 0; i < 7; i++) tick();
    i_halt_WB = 1'b1;
    tick();
    i_halt_WB = 1'b0;
    check("wd+halt b", {b_state, b_timeout}, 3'b111);
    check("halt only a", {a_state, a_timeout}, 3'b110);

    // Randomised stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        i_rst_n = 1'b0;
        model_reset();
        #1 check_model("rand reset");
        tick();
        i_rst_n = 1'b1;
      end else begin
        set_in($urandom_range(0, 99) < 85, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 9) < 3);
        #1 check_model("rand");
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pipeline_sequencer
